// File: rtl/inverse_binomial_transform.sv
// inverse_binomial_transform: rebuilds a[n] from leading-diagonal differences d[k] by in-place prefix summation; `define IBT_OVF_FLAG_EN adds a sticky signed-overflow output ovf
module inverse_binomial_transform #(
  parameter int N = 10,
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
`ifdef IBT_OVF_FLAG_EN
  output logic         ovf,
`endif
  output logic         busy
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic [CW-1:0] PEN  = CW'(N - 2);
  localparam logic [1:0] LOAD = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SEND = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, ci_q, ci_d, cj_q, cj_d, k_q, k_d, cj_nx;
  logic [W-1:0]  x_q [N];
  logic [W-1:0]  x_d [N];
  logic [W-1:0]  add_a, add_b, add_s;
`ifdef IBT_OVF_FLAG_EN
  logic          ovf_q, ovf_d, add_ovf;
  assign add_ovf = (add_a[W-1] == add_b[W-1]) && (add_s[W-1] != add_a[W-1]);
  assign ovf     = ovf_q;
`endif
  assign cj_nx     = cj_q + 1'b1;
  assign add_a     = x_q[cj_nx];
  assign add_b     = x_q[cj_q];
  assign add_s     = add_a + add_b;
  assign in_ready  = state_q == LOAD;
  assign busy      = state_q == CALC;
  assign out_valid = state_q == SEND;
  assign out_data  = out_valid ? x_q[k_q] : '0;
  assign out_last  = out_valid && (k_q == LAST);
  // next-state: load words, sweep one x[j+1] += x[j] per cycle (i = N-2..0, j = i..N-2), then stream out
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ci_d    = ci_q;
    cj_d    = cj_q;
    k_d     = k_q;
    x_d     = x_q;
`ifdef IBT_OVF_FLAG_EN
    ovf_d   = ovf_q;
`endif
    if (state_q == LOAD) begin
      if (in_valid) begin
        x_d[cnt_q] = in_data;
        cnt_d      = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = CALC;
          ci_d    = PEN;
          cj_d    = PEN;
`ifdef IBT_OVF_FLAG_EN
          ovf_d   = 1'b0;
`endif
        end
      end
    end else if (state_q == CALC) begin
      x_d[cj_nx] = add_s;
`ifdef IBT_OVF_FLAG_EN
      ovf_d      = ovf_q | add_ovf;
`endif
      if (cj_q != PEN) cj_d = cj_nx;
      else if (ci_q != '0) begin
        ci_d = ci_q - 1'b1;
        cj_d = ci_q - 1'b1;
      end else begin
        state_d = SEND;
        k_d     = '0;
      end
    end else if (state_q == SEND) begin
      if (out_ready) begin
        k_d = (k_q == LAST) ? '0 : k_q + 1'b1;
        if (k_q == LAST) state_d = LOAD;
      end
    end else state_d = LOAD;
  end
  // state registers; reset clears everything so a partial block is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      ci_q    <= '0;
      cj_q    <= '0;
      k_q     <= '0;
      x_q     <= '{default: '0};
`ifdef IBT_OVF_FLAG_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ci_q    <= ci_d;
      cj_q    <= cj_d;
      k_q     <= k_d;
      x_q     <= x_d;
`ifdef IBT_OVF_FLAG_EN
      ovf_q   <= ovf_d;
`endif
    end
  end
endmodule
